// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and memory (slave).
// imem_req is the request valid and imem_ack is the completion. A word
// transfers in any cycle where imem_req && imem_ack. imem_ack may be high in
// the first request cycle. imem_addr stays stable from the start of a request
// until its completion. Only one request is outstanding at a time.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Pipeline IF stage: program counter, instruction-memory request FSM, one-entry
// hold buffer for stalled fetches, and the IF/ID pipeline register.
module fetch_unit (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                StallF,
  input  logic                StallD,
  input  logic                FlushD,
  input  logic                PCSrcE,
  input  logic [31:0]         PCTargetE,
  fetch_unit_if.master        bus,
  output logic [31:0]         InstrD,
  output logic [31:0]         PCD,
  output logic [31:0]         PCPlus4D,
  output logic                ValidD,
  output logic                FetchBusyF,
  output logic [1:0]          o_dbg_state
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      r_state;
  logic [31:0] r_pcf;
  logic [31:0] r_redir;
  logic [31:0] r_hold_buf;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic [31:0] r_pc4_d;
  logic        r_valid_d;

  state_t      w_state_n;
  logic [31:0] w_pcf_n;
  logic [31:0] w_redir_n;
  logic [31:0] w_hold_n;
  logic        w_load;
  logic [31:0] w_load_word;
  logic        w_done;
  logic [31:0] w_pc_plus4;

  // No request while in reset, so an ack seen during reset never completes.
  assign bus.imem_req  = rst_n && (r_state != S_HOLD);
  assign bus.imem_addr = r_pcf;
  assign w_done        = bus.imem_req && bus.imem_ack;
  assign w_pc_plus4    = r_pcf + 32'd4;

  always_comb begin
    w_state_n   = r_state;
    w_pcf_n     = r_pcf;
    w_redir_n   = r_redir;
    w_hold_n    = r_hold_buf;
    w_load      = 1'b0;
    w_load_word = bus.imem_rdata;
    case (r_state)
      S_FETCH: begin
        if (PCSrcE) begin
          if (w_done) begin
            w_pcf_n = PCTargetE;
          end else begin
            // Address must stay put until the outstanding request completes.
            w_redir_n = PCTargetE;
            w_state_n = S_DISCARD;
          end
        end else if (w_done) begin
          if (StallF || StallD) begin
            w_hold_n  = bus.imem_rdata;
            w_state_n = S_HOLD;
          end else begin
            w_load  = 1'b1;
            w_pcf_n = w_pc_plus4;
          end
        end
      end
      S_HOLD: begin
        if (PCSrcE) begin
          w_pcf_n   = PCTargetE;
          w_state_n = S_FETCH;
        end else if (!StallF && !StallD) begin
          w_load      = 1'b1;
          w_load_word = r_hold_buf;
          w_pcf_n     = w_pc_plus4;
          w_state_n   = S_FETCH;
        end
      end
      S_DISCARD: begin
        if (PCSrcE) w_redir_n = PCTargetE;
        if (w_done) begin
          w_pcf_n   = PCSrcE ? PCTargetE : r_redir;
          w_state_n = S_FETCH;
        end
      end
      default: w_state_n = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_pcf      <= 32'h0;
      r_redir    <= 32'h0;
      r_hold_buf <= 32'h0;
    end else begin
      r_state    <= w_state_n;
      r_pcf      <= w_pcf_n;
      r_redir    <= w_redir_n;
      r_hold_buf <= w_hold_n;
    end
  end

  // IF/ID priority: flush, then stall, then new word, otherwise bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_d <= NOP;
      r_pc_d    <= 32'h0;
      r_pc4_d   <= 32'h0;
      r_valid_d <= 1'b0;
    end else if (FlushD) begin
      r_instr_d <= NOP;
      r_pc_d    <= 32'h0;
      r_pc4_d   <= 32'h0;
      r_valid_d <= 1'b0;
    end else if (StallD) begin
      r_instr_d <= r_instr_d;
    end else if (w_load) begin
      r_instr_d <= w_load_word;
      r_pc_d    <= r_pcf;
      r_pc4_d   <= w_pc_plus4;
      r_valid_d <= 1'b1;
    end else begin
      r_instr_d <= NOP;
      r_pc_d    <= 32'h0;
      r_pc4_d   <= 32'h0;
      r_valid_d <= 1'b0;
    end
  end

  assign InstrD      = r_instr_d;
  assign PCD         = r_pc_d;
  assign PCPlus4D    = r_pc4_d;
  assign ValidD      = r_valid_d;
  assign FetchBusyF  = (r_state == S_FETCH && !bus.imem_ack) || (r_state == S_DISCARD);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: latency-programmable memory model, IF/ID
// scoreboard fed with expected {PCD, PCPlus4D, InstrD} tuples.
module tb_fetch_unit;

  localparam logic [1:0] ST_FETCH   = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD, FetchBusyF;
  logic [1:0]  o_dbg_state;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          wait_n;
  int          r_cnt;
  logic [31:0] salt;
  logic [95:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .bus        (bus.master),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD),
    .FetchBusyF (FetchBusyF),
    .o_dbg_state(o_dbg_state)
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ salt;
  endfunction

  // Memory: acks once the request has waited wait_n cycles; garbage otherwise.
  assign bus.imem_ack   = bus.imem_req && (r_cnt >= wait_n);
  assign bus.imem_rdata = bus.imem_ack ? mem_f(bus.imem_addr) : 32'hBAD0_BAD0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)             r_cnt <= 0;
    else if (bus.imem_ack)  r_cnt <= 0;
    else if (bus.imem_req)  r_cnt <= r_cnt + 1;
  end

  task automatic chk(input string tag, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    logic [31:0] pc4;
    pc4 = pc + 32'd4;
    exp_q.push_back({pc, pc4, mem_f(pc)});
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: every cycle IF/ID was free to update and holds a valid word.
  always @(posedge clk) begin
    logic        sd;
    logic        rn;
    logic [95:0] e;
    sd = StallD;
    rn = rst_n;
    #1;
    if (rn && rst_n && !sd && ValidD) begin
      if (exp_q.size() == 0) begin
        chk("ifid_unexpected_valid", {95'h0, ValidD}, 96'h0);
      end else begin
        e = exp_q.pop_front();
        chk("ifid_word", {PCD, PCPlus4D, InstrD}, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    salt      = $urandom_range(32'h7FFF_FFFF, 1);
    rst_n     = 1'b0;
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b0;
    PCSrcE    = 1'b0;
    PCTargetE = 32'h0;
    wait_n    = 0;
    repeat (2) @(posedge clk);
    #2;

    // Reset state
    chk("rst_req",    {95'h0, bus.imem_req}, 96'h0);
    chk("rst_addr",   {64'h0, bus.imem_addr}, 96'h0);
    chk("rst_valid",  {95'h0, ValidD}, 96'h0);
    chk("rst_instr",  {64'h0, InstrD}, {64'h0, NOP});
    chk("rst_pcd",    {64'h0, PCD}, 96'h0);
    chk("rst_pc4d",   {64'h0, PCPlus4D}, 96'h0);
    chk("rst_state",  {94'h0, o_dbg_state}, {94'h0, ST_FETCH});

    // Zero-wait straight-line fetch from 0
    for (int i = 0; i < 4; i++) push_exp(32'(i * 4));
    rst_n = 1'b1;
    #1;
    chk("req_after_rst", {95'h0, bus.imem_req}, 96'h1);
    repeat (4) step();

    // Three-cycle ack latency at 0x10
    wait_n = 2;
    #1;
    chk("lat_addr",  {64'h0, bus.imem_addr}, 96'h10);
    chk("lat_busy0", {95'h0, FetchBusyF}, 96'h1);
    push_exp(32'h10);
    step();
    chk("lat_busy1",  {95'h0, FetchBusyF}, 96'h1);
    chk("lat_bubble", {64'h0, InstrD}, {64'h0, NOP});
    chk("lat_valid1", {95'h0, ValidD}, 96'h0);
    step();
    chk("lat_busy2",  {95'h0, FetchBusyF}, 96'h0);
    chk("lat_valid2", {95'h0, ValidD}, 96'h0);
    step();
    wait_n = 0;
    for (int a = 'h14; a < 'h20; a += 4) push_exp(32'(a));
    repeat (3) step();

    // Stall at 0x20: hold buffer, flush in HOLD must not lose the buffer
    StallF = 1'b1;
    StallD = 1'b1;
    #1;
    chk("hold_addr_pre", {64'h0, bus.imem_addr}, 96'h20);
    step();
    chk("hold_state", {94'h0, o_dbg_state}, {94'h0, ST_HOLD});
    chk("hold_req",   {95'h0, bus.imem_req}, 96'h0);
    chk("hold_pcd",   {64'h0, PCD}, 96'h1C);
    chk("hold_valid", {95'h0, ValidD}, 96'h1);
    FlushD = 1'b1;
    step();
    FlushD = 1'b0;
    chk("hold_state2",  {94'h0, o_dbg_state}, {94'h0, ST_HOLD});
    chk("hold_flushed", {95'h0, ValidD}, 96'h0);
    chk("hold_addr",    {64'h0, bus.imem_addr}, 96'h20);
    StallF = 1'b0;
    StallD = 1'b0;
    push_exp(32'h20);
    step();
    chk("hold_pcf_next", {64'h0, bus.imem_addr}, 96'h24);
    chk("hold_release_state", {94'h0, o_dbg_state}, {94'h0, ST_FETCH});

    // Redirect while 0x40 is outstanding
    for (int a = 'h24; a < 'h40; a += 4) push_exp(32'(a));
    repeat (7) step();
    wait_n    = 3;
    PCSrcE    = 1'b1;
    PCTargetE = 32'h100;
    step();
    PCSrcE = 1'b0;
    chk("disc_state", {94'h0, o_dbg_state}, {94'h0, ST_DISCARD});
    chk("disc_addr",  {64'h0, bus.imem_addr}, 96'h40);
    chk("disc_busy",  {95'h0, FetchBusyF}, 96'h1);
    chk("disc_valid", {95'h0, ValidD}, 96'h0);
    repeat (3) step();
    chk("disc_done_state", {94'h0, o_dbg_state}, {94'h0, ST_FETCH});
    chk("disc_new_addr",   {64'h0, bus.imem_addr}, 96'h100);
    chk("disc_dropped",    {95'h0, ValidD}, 96'h0);

    // Newer redirect while already discarding replaces the pending target
    wait_n    = 2;
    PCSrcE    = 1'b1;
    PCTargetE = 32'h300;
    step();
    chk("redir2_state", {94'h0, o_dbg_state}, {94'h0, ST_DISCARD});
    PCTargetE = 32'h340;
    step();
    PCSrcE = 1'b0;
    chk("redir2_stable", {64'h0, bus.imem_addr}, 96'h100);
    step();
    chk("redir2_addr", {64'h0, bus.imem_addr}, 96'h340);

    // Redirect + flush in the completion cycle at 0x50
    wait_n    = 0;
    PCSrcE    = 1'b1;
    PCTargetE = 32'h50;
    step();
    chk("to50_addr", {64'h0, bus.imem_addr}, 96'h50);
    FlushD    = 1'b1;
    PCTargetE = 32'h200;
    step();
    FlushD = 1'b0;
    PCSrcE = 1'b0;
    chk("flush_valid", {95'h0, ValidD}, 96'h0);
    chk("flush_instr", {64'h0, InstrD}, {64'h0, NOP});
    chk("flush_pcd",   {64'h0, PCD}, 96'h0);
    chk("flush_addr",  {64'h0, bus.imem_addr}, 96'h200);
    push_exp(32'h200);
    push_exp(32'h204);
    repeat (2) step();

    // Wrap-around at the top of the address space
    PCSrcE    = 1'b1;
    PCTargetE = 32'hFFFF_FFFC;
    step();
    PCSrcE = 1'b0;
    chk("wrap_addr0", {64'h0, bus.imem_addr}, {64'h0, 32'hFFFF_FFFC});
    push_exp(32'hFFFF_FFFC);
    push_exp(32'h0);
    step();
    chk("wrap_addr1", {64'h0, bus.imem_addr}, 96'h0);
    chk("wrap_pc4d",  {64'h0, PCPlus4D}, 96'h0);
    step();
    chk("wrap_addr2", {64'h0, bus.imem_addr}, 96'h4);

    // Asynchronous reset in the middle of an outstanding request
    wait_n = 5;
    step();
    chk("mid_busy", {95'h0, FetchBusyF}, 96'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_req",   {95'h0, bus.imem_req}, 96'h0);
    chk("async_addr",  {64'h0, bus.imem_addr}, 96'h0);
    chk("async_valid", {95'h0, ValidD}, 96'h0);
    chk("async_state", {94'h0, o_dbg_state}, {94'h0, ST_FETCH});
    step();
    wait_n = 0;
    push_exp(32'h0);
    push_exp(32'h4);
    rst_n = 1'b1;
    repeat (2) step();

    chk("queue_empty", 96'(exp_q.size()), 96'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
